// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire NRZ encoder: a double-buffered 24-bit GRB word stream in,
// one registered line drive out, with a latch low period after each frame.
module ws2812_bit_encoder #(
  parameter int T0H_CNT  = 32,
  parameter int T1H_CNT  = 64,
  parameter int TBIT_CNT = 100,
  parameter int RST_CNT  = 24000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        data_valid_in,
  input  logic [23:0] data_in,
  input  logic        last_in,
  output logic        data_ready_out,
  output logic        busy_out,
  output logic        underrun_out,
  output logic        bit_out
);

  localparam int CNT_W = (TBIT_CNT > 1) ? $clog2(TBIT_CNT) : 1;
  localparam int LAT_W = (RST_CNT > 1) ? $clog2(RST_CNT) : 1;

  localparam logic [CNT_W-1:0] T0H_C     = CNT_W'(T0H_CNT);
  localparam logic [CNT_W-1:0] T1H_C     = CNT_W'(T1H_CNT);
  localparam logic [CNT_W-1:0] TBIT_LAST = CNT_W'(TBIT_CNT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RST_CNT - 1);
  localparam logic [4:0]       IDX_LAST  = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LATCH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         idx_q, idx_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [23:0]        shift_q, shift_d;
  logic               shift_last_q, shift_last_d;
  logic [23:0]        hold_data_q, hold_data_d;
  logic               hold_last_q, hold_last_d;
  logic               hold_valid_q, hold_valid_d;
  logic               underrun_q, underrun_d;
  logic               bit_q, bit_d;
  logic               load;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    underrun_d   = 1'b0;
    load         = 1'b0;

    if (data_valid_in && !hold_valid_q) begin
      hold_data_d  = data_in;
      hold_last_d  = last_in;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_valid_q) load = 1'b1;
      end
      SEND: begin
        if (cnt_q == TBIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (shift_last_q) begin
              state_d = LATCH;
              lat_d   = '0;
            end else if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d    = IDLE;
              underrun_d = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (lat_q == LAT_LAST) begin
          if (hold_valid_q) load = 1'b1;
          else              state_d = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading needs a full hold register and accepting needs an empty one,
    // so the two never coincide on one edge.
    if (load) begin
      shift_d      = hold_data_q;
      shift_last_d = hold_last_q;
      hold_valid_d = 1'b0;
      state_d      = SEND;
      cnt_d        = '0;
      idx_d        = '0;
    end

    // Line drive is computed from the next state so bit_out_q tracks cnt_q exactly.
    bit_d = (state_d == SEND) && (cnt_d < (shift_d[23] ? T1H_C : T0H_C));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      lat_q        <= '0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      underrun_q   <= underrun_d;
      bit_q        <= bit_d;
    end
  end

  assign data_ready_out = ~hold_valid_q;
  assign busy_out       = (state_q != IDLE);
  assign underrun_out   = underrun_q;
  assign bit_out        = bit_q;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Directed bench for ws2812_bit_encoder: default timing instance plus a
// small-parameter instance, checked cycle by cycle on the falling edge.
module tb_ws2812_bit_encoder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_valid = 1'b0;
  logic [23:0] tb_data  = '0;
  logic        tb_last  = 1'b0;
  logic        sel      = 1'b0;

  logic v0, v1;
  logic rdy0, busy0, und0, bit0;
  logic rdy1, busy1, und1, bit1;
  logic s_rdy, s_busy, s_und, s_bit;

  int checks = 0;
  int errors = 0;
  int tbit = 100, t0 = 32, t1 = 64, rst_cnt = 24000;

  logic [23:0] qd[$];
  logic        ql[$];
  logic        xfer_pending = 1'b0;

  always #5 clk = ~clk;

  assign v0 = tb_valid & ~sel;
  assign v1 = tb_valid & sel;
  assign s_rdy  = sel ? rdy1  : rdy0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_und  = sel ? und1  : und0;
  assign s_bit  = sel ? bit1  : bit0;

  ws2812_bit_encoder dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .data_valid_in(v0), .data_in(tb_data),
    .last_in(tb_last), .data_ready_out(rdy0), .busy_out(busy0),
    .underrun_out(und0), .bit_out(bit0)
  );

  ws2812_bit_encoder #(.T0H_CNT(2), .T1H_CNT(4), .TBIT_CNT(6), .RST_CNT(10)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .data_valid_in(v1), .data_in(tb_data),
    .last_in(tb_last), .data_ready_out(rdy1), .busy_out(busy1),
    .underrun_out(und1), .bit_out(bit1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Upstream driver: called once per falling edge, presents queued words and
  // retires one when the previous rising edge saw valid & ready.
  task automatic feed();
    if (tb_valid && xfer_pending) begin
      void'(qd.pop_front());
      void'(ql.pop_front());
      check("ready_low_after_accept", {31'd0, s_rdy}, 32'd0);
    end
    if (qd.size() > 0) begin
      tb_valid = 1'b1;
      tb_data  = qd[0];
      tb_last  = ql[0];
    end else begin
      tb_valid = 1'b0;
    end
    xfer_pending = tb_valid && (s_rdy === 1'b1);
  endtask

  task automatic push(input logic [23:0] w, input logic l);
    qd.push_back(w);
    ql.push_back(l);
  endtask

  task automatic wait_rise(input int budget);
    int n = 0;
    while (s_bit !== 1'b1 && n < budget) begin
      feed();
      @(negedge clk);
      n++;
    end
    check("start_within_budget", {31'd0, s_bit}, 32'd1);
  endtask

  // Entered on the falling edge of the word's first cycle; leaves on the
  // falling edge of the cycle after its last bit.
  task automatic check_word(input logic [23:0] w);
    check("ready_high_at_word_start", {31'd0, s_rdy}, 32'd1);
    for (int i = 0; i < 24; i++) begin
      int th, hi, bad, und, idle;
      th   = w[23 - i] ? t1 : t0;
      hi   = 0;
      bad  = 0;
      und  = 0;
      idle = 0;
      for (int c = 0; c < tbit; c++) begin
        if (s_bit === 1'b1) hi++;
        if (s_bit !== logic'(c < th)) bad++;
        if (s_und !== 1'b0) und++;
        if (s_busy !== 1'b1) idle++;
        feed();
        @(negedge clk);
      end
      check($sformatf("bit%0d_high_cycles", i), hi, th);
      check($sformatf("bit%0d_shape_errs", i), bad, 0);
      check($sformatf("bit%0d_underrun_or_idle", i), und + idle, 0);
    end
  endtask

  task automatic check_latch(input logic inject, input logic [23:0] iw, input logic il);
    int lo = 0;
    int bz = 0;
    for (int c = 0; c < rst_cnt; c++) begin
      if (s_bit === 1'b0) lo++;
      if (s_busy === 1'b1) bz++;
      if (inject && c == rst_cnt / 4) push(iw, il);
      feed();
      @(negedge clk);
    end
    check("latch_low_cycles", lo, rst_cnt);
    check("latch_busy_cycles", bz, rst_cnt);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'd0, s_busy}, 32'd0);
    check({tag, "_bit"},  {31'd0, s_bit},  32'd0);
    check({tag, "_ready"}, {31'd0, s_rdy}, 32'd1);
  endtask

  task automatic check_underrun();
    int act = 0;
    check("underrun_pulse", {31'd0, s_und}, 32'd1);
    check_idle("after_underrun");
    feed();
    @(negedge clk);
    check("underrun_one_cycle", {31'd0, s_und}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      if (s_busy !== 1'b0 || s_bit !== 1'b0 || s_und !== 1'b0) act++;
      feed();
      @(negedge clk);
    end
    check("no_latch_after_underrun", act, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    check("in_reset_underrun", {31'd0, und0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    // Single word, latched frame end.
    push(24'hA500FF, 1'b1);
    wait_rise(10);
    check_word(24'hA500FF);
    check_latch(1'b0, 24'h0, 1'b0);
    check_idle("after_single_latch");

    // Three streamed words, then a word queued during the latch period.
    push(24'h0F0F0F, 1'b0);
    push(24'h3C3C3C, 1'b0);
    push(24'h96C35A, 1'b1);
    wait_rise(10);
    check_word(24'h0F0F0F);
    check_word(24'h3C3C3C);
    check_word(24'h96C35A);
    check_latch(1'b1, 24'hFFFFFF, 1'b0);
    check("queued_word_accepted", qd.size(), 0);
    check_word(24'hFFFFFF);
    check_underrun();

    // Asynchronous reset while the line is high in bit 5.
    push(24'h5A5A5A, 1'b0);
    wait_rise(10);
    for (int c = 0; c < 5 * tbit + 10; c++) begin
      feed();
      @(negedge clk);
    end
    check("pre_reset_high", {31'd0, s_bit}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    tb_valid = 1'b0;
    qd.delete();
    ql.delete();
    xfer_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_mid_reset");

    // Fresh word after reset, no successor: underrun.
    push(24'h000001, 1'b0);
    wait_rise(10);
    check_word(24'h000001);
    check_underrun();

    // Small-parameter instance.
    sel = 1'b1;
    tbit = 6; t0 = 2; t1 = 4; rst_cnt = 10;
    @(negedge clk);
    check_idle("small_idle");
    push(24'h800000, 1'b1);
    wait_rise(10);
    check_word(24'h800000);
    check_latch(1'b0, 24'h0, 1'b0);
    check_idle("small_after_latch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_bit_encoder.md
# ws2812_bit_encoder

Serialises 24-bit GRB pixel words into the WS2812 single-wire NRZ waveform for one LED channel. Sits directly downstream of the controller's pixel frame store, with one instance per `ws2812_data_out` bit. It accepts words over a valid/ready handshake and double-buffers them so consecutive pixels stream with no gap. After a word tagged as last, it emits the latch (reset) low period.

## Interface
- `T0H_CNT`, default 32: high cycles for a 0 bit (0.40 µs at 80 MHz).
- `T1H_CNT`, default 64: high cycles for a 1 bit (0.80 µs).
- `TBIT_CNT`, default 100: total cycles per bit (1.25 µs).
- `RST_CNT`, default 24000: low cycles for the latch period (300 µs).
- `clk_in` input 1: single clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `data_valid_in` input 1: `data_in` and `last_in` are valid.
- `data_in` input 24: pixel word; bit 23 (G7) is sent first, bit 0 (B0) last.
- `last_in` input 1: this word ends the frame; the latch period follows it.
- `data_ready_out` output 1: the encoder can accept a word.
- `busy_out` output 1: FSM is not in IDLE.
- `underrun_out` output 1: one-cycle pulse when the hold register is empty at the end of a non-last word.
- `bit_out` output 1: registered WS2812 line drive.

## Operation
- Hold register: one word plus its `last` flag, and `hold_valid`.
  - `data_ready_out = ~hold_valid`. Purely register-driven, with no combinational path from `data_valid_in`.
  - A transfer occurs on an edge where `data_valid_in & data_ready_out`.
- Shift register: 24 bits plus a latched `last` flag. It is loaded from the hold register, which clears `hold_valid`.
- Counters:
  - Bit-phase `cnt` runs 0..TBIT_CNT-1.
  - Bit index runs 0..23.
  - Latch counter runs 0..RST_CNT-1.
  - Each counter is `$clog2` of its maximum value wide.
- FSM states: IDLE, SEND, LATCH.
  - IDLE: `bit_out`=0. If `hold_valid`, load the shifter and go to SEND with `cnt`=0 and index=0.
  - SEND: `bit_out` is registered as `(cnt < (cur_bit ? T1H_CNT : T0H_CNT))`. At `cnt`=TBIT_CNT-1 the next bit starts.
  - End of bit 23 at `cnt`=TBIT_CNT-1, in priority order:
    - shifter `last`=1: go to LATCH.
    - else if `hold_valid`: load the next word and stay in SEND, giving a seamless bit stream.
    - else: go to IDLE and pulse `underrun_out`.
  - LATCH: `bit_out`=0 for exactly RST_CNT cycles. Words may be accepted into the hold register during LATCH. On expiry, if `hold_valid`, load and go to SEND directly; otherwise go to IDLE.
- `busy_out` = (state != IDLE).
- Simultaneous events: the shifter loading from hold and a new upstream transfer on the same edge is impossible, because ready is low while the hold register is full. The hold register frees on the load edge, and ready rises the following cycle.
- Reset (asynchronous, also mid-frame):
  - `bit_out`=0, `data_ready_out`=1, `busy_out`=0, `underrun_out`=0, state=IDLE.
  - Hold and shift contents are discarded. No latch period is generated.
- Parameter legality: 0 < T0H_CNT < T1H_CNT < TBIT_CNT, and RST_CNT ≥ 1. Other values are unsupported.

## Timing
- Word accepted at edge E0: `data_ready_out` low after E0.
- At E1, IDLE loads the shifter. `bit_out` rises after E1 (1-cycle latency) and `data_ready_out` returns high after E1.
- One pixel = 24×TBIT_CNT cycles = 2400 cycles at defaults.
- A 1 bit is high for T1H_CNT cycles then low for TBIT_CNT−T1H_CNT. A 0 bit is high for T0H_CNT cycles then low for the remainder.
- Back-to-back words: the first cycle of the next word's bit 23 immediately follows the last cycle of the previous bit 0. No idle cycle is inserted.
- Latch: `bit_out` is low from the end of the last bit for RST_CNT cycles, then the next SEND (if queued) starts on the following cycle.
- `underrun_out` asserts in the cycle after the final `cnt` of bit 0 and deasserts one cycle later.

## Test plan
- **Single word:** send 0xA5_00_FF with `last_in`=1.
  - Bit highs are 64,32,64,32,32,64,32,64 cycles, then 8×32, then 8×64, each bit exactly 100 cycles.
  - This is followed by exactly 24000 low cycles, then `busy_out`=0.
- **Streaming:** three words with `data_valid_in` held high, the third with `last_in`.
  - 7200 contiguous bit cycles with no gap.
  - `data_ready_out` pattern: low 1 cycle after each accept, high again after each load.
- **Underrun:** one word 0x000001 with `last_in`=0 and no second word.
  - After 2400 cycles, `underrun_out` pulses once, state=IDLE, `bit_out`=0, and no latch period occurs.
- **Queue during latch:** after a `last_in` word, present 0xFFFFFF partway through LATCH.
  - It is accepted (hold fills, ready drops).
  - The first high of 64 cycles starts exactly 1 cycle after the 24000th low cycle.
- **Reset mid-bit:** assert `rst_n_in` while `bit_out`=1 during bit 5.
  - `bit_out`=0 immediately (asynchronously) and `data_ready_out`=1.
  - After release, a new word is encoded from its bit 23 with correct timing.
- **Parameter override:** T0H_CNT=2, T1H_CNT=4, TBIT_CNT=6, RST_CNT=10 with word 0x800000.
  - First bit high 4 / low 2, remaining 23 bits high 2 / low 4, then 10 low cycles.
